// File: rtl/i2s_stream_tx.sv
// ============================================================================
// i2s_stream_tx : I2S master transmitter on mck with a stereo-pair FIFO.
// Optional macro I2S_TX_HOLD_LAST_EN: an underrun frame repeats the last pair.
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2s_stream_tx #(
    parameter int WIDTH         = 24,
    parameter int BITS_PER_SLOT = 32,
    parameter int MCK_PER_BCK   = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          mck,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_left,
    input  logic [WIDTH-1:0]              in_right,
    output logic                          bck,
    output logic                          lrck,
    output logic                          sdata,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DW = $clog2(MCK_PER_BCK);
    localparam int CW = $clog2(2 * BITS_PER_SLOT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [DW-1:0] c_div_last = DW'(MCK_PER_BCK - 1);
    localparam logic [DW-1:0] c_div_rise = DW'(MCK_PER_BCK / 2 - 1);
    localparam logic [CW-1:0] c_cnt_last = CW'(2 * BITS_PER_SLOT - 1);
    localparam logic [CW-1:0] c_slot     = CW'(BITS_PER_SLOT);
    localparam logic [CW-1:0] c_width    = CW'(WIDTH);
    localparam logic [LW-1:0] c_depth    = LW'(FIFO_DEPTH);

    logic [DW-1:0]    r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_bck;
    logic             r_lrck;
    logic             r_sdata;
    logic             r_underrun;
    logic [WIDTH-1:0] r_left;
    logic [WIDTH-1:0] r_right;
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_mem_l [FIFO_DEPTH];
    logic [WIDTH-1:0] r_mem_r [FIFO_DEPTH];
`ifdef I2S_TX_HOLD_LAST_EN
    logic [WIDTH-1:0] r_last_l;
    logic [WIDTH-1:0] r_last_r;
`endif

    logic             w_fall;
    logic             w_rise;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_lr_nxt;
    logic [CW-1:0]    w_pos;
    logic             w_data_bit;
    logic             w_fstart;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        w_fall     = (r_div == c_div_last);
        w_rise     = (r_div == c_div_rise);
        w_cnt_nxt  = (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
        w_lr_nxt   = (w_cnt_nxt >= c_slot);
        w_pos      = w_lr_nxt ? (w_cnt_nxt - c_slot) : w_cnt_nxt;
        // Slot position 0 is the one-bck I2S delay; data occupies 1..WIDTH.
        w_data_bit = (w_pos != '0) && (w_pos <= c_width);
        w_fstart   = w_fall && (w_cnt_nxt == '0);
        w_empty    = (r_level == '0);
        w_pop      = w_fstart && !w_empty;
        w_push     = in_valid && in_ready;
    end

    assign in_ready   = (r_level != c_depth);
    assign fifo_level = r_level;
    assign bck        = r_bck;
    assign lrck       = r_lrck;
    assign sdata      = r_sdata;
    assign underrun   = r_underrun;

    always_ff @(posedge mck or negedge reset_n) begin
        if (!reset_n) begin
            r_div      <= '0;
            r_cnt      <= c_cnt_last;
            r_bck      <= 1'b0;
            r_lrck     <= 1'b1;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
            r_left     <= '0;
            r_right    <= '0;
`ifdef I2S_TX_HOLD_LAST_EN
            r_last_l   <= '0;
            r_last_r   <= '0;
`endif
        end else begin
            r_div      <= w_fall ? '0 : r_div + 1'b1;
            r_underrun <= w_fstart && w_empty;
            if (w_rise) begin
                r_bck <= 1'b1;
            end else if (w_fall) begin
                r_bck <= 1'b0;
            end
            if (w_fall) begin
                r_cnt  <= w_cnt_nxt;
                r_lrck <= w_lr_nxt;
                if (w_fstart) begin
                    r_sdata <= 1'b0;
                    if (w_pop) begin
                        r_left  <= r_mem_l[r_rd];
                        r_right <= r_mem_r[r_rd];
`ifdef I2S_TX_HOLD_LAST_EN
                        r_last_l <= r_mem_l[r_rd];
                        r_last_r <= r_mem_r[r_rd];
`endif
                    end else begin
`ifdef I2S_TX_HOLD_LAST_EN
                        r_left  <= r_last_l;
                        r_right <= r_last_r;
`else
                        r_left  <= '0;
                        r_right <= '0;
`endif
                    end
                end else if (w_data_bit) begin
                    if (w_lr_nxt) begin
                        r_sdata <= r_right[WIDTH-1];
                        r_right <= r_right << 1;
                    end else begin
                        r_sdata <= r_left[WIDTH-1];
                        r_left  <= r_left << 1;
                    end
                end else begin
                    r_sdata <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge mck) begin
        if (w_push) begin
            r_mem_l[r_wr] <= in_left;
            r_mem_r[r_wr] <= in_right;
        end
    end

    always_ff @(posedge mck or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2s_stream_tx.sv
// ============================================================================
// tb_i2s_stream_tx : scoreboard bench for i2s_stream_tx.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_i2s_stream_tx;

    localparam int W = 24;
    localparam int B = 32;
    localparam int M = 4;
    localparam int D = 4;

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] r;
    } pair_t;

    logic             mck;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_left;
    logic [W-1:0]     in_right;
    logic             bck;
    logic             lrck;
    logic             sdata;
    logic             underrun;
    logic [$clog2(D):0] fifo_level;

    i2s_stream_tx #(
        .WIDTH(W), .BITS_PER_SLOT(B), .MCK_PER_BCK(M), .FIFO_DEPTH(D)
    ) u_dut (
        .mck(mck), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_left(in_left), .in_right(in_right), .bck(bck), .lrck(lrck),
        .sdata(sdata), .underrun(underrun), .fifo_level(fifo_level)
    );

    initial mck = 1'b0;
    always #5 mck = ~mck;

    int     n_total = 0;
    int     n_bad   = 0;

    pair_t  m_q[$];
    pair_t  cur;
    pair_t  m_last;
    int     m_div;
    int     m_cnt;
    logic   m_fall;
    logic   m_rise;
    logic   m_fstart;
    logic   m_unr;
    logic   m_pushed;
    logic   collecting;
    logic [2*B-1:0] frm;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_q.delete();
        m_div      = 0;
        m_cnt      = 2*B - 1;
        m_last     = '0;
        cur        = '0;
        m_fall     = 1'b0;
        m_rise     = 1'b0;
        m_fstart   = 1'b0;
        m_unr      = 1'b0;
        m_pushed   = 1'b0;
        collecting = 1'b0;
        frm        = '0;
    endtask

    task automatic check_frame();
        logic [W-1:0] got_l;
        logic [W-1:0] got_r;
        logic         pad;
        got_l = '0;
        got_r = '0;
        pad   = 1'b0;
        for (int p = 0; p < B; p++) begin
            if (p >= 1 && p <= W) begin
                got_l[W-p] = frm[p];
                got_r[W-p] = frm[B+p];
            end else begin
                pad = pad | frm[p] | frm[B+p];
            end
        end
        chk("left", 32'(got_l), 32'(cur.l));
        chk("right", 32'(got_r), 32'(cur.r));
        chk("pad", 32'(pad), 32'd0);
    endtask

    task automatic tick();
        logic was_ready;
        was_ready = (m_q.size() != D);
        @(posedge mck);
        m_fall   = (m_div == M-1);
        m_rise   = (m_div == M/2-1);
        m_div    = m_fall ? 0 : m_div + 1;
        m_pushed = in_valid && was_ready;
        m_fstart = 1'b0;
        m_unr    = 1'b0;
        if (m_fall) begin
            m_cnt = (m_cnt == 2*B-1) ? 0 : m_cnt + 1;
            if (m_cnt == 0) begin
                m_fstart = 1'b1;
                if (m_q.size() > 0) begin
                    cur    = m_q.pop_front();
                    m_last = cur;
                end else begin
                    m_unr = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
                    cur = m_last;
`else
                    cur = '0;
`endif
                end
            end
        end
        if (m_pushed) m_q.push_back({in_left, in_right});
        #1;
        chk("level", 32'(fifo_level), 32'(m_q.size()));
        chk("ready", 32'(in_ready), 32'(m_q.size() != D));
        chk("underrun", 32'(underrun), 32'(m_unr));
        if (m_rise) chk("bck_rise", 32'(bck), 32'd1);
        if (m_fall) begin
            chk("bck_fall", 32'(bck), 32'd0);
            chk("lrck", 32'(lrck), 32'(m_cnt >= B));
            frm[m_cnt] = sdata;
            if (m_cnt == 0) collecting = 1'b1;
            if (m_cnt == 2*B-1 && collecting) check_frame();
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_fstart();
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!m_fstart && k < 400);
        if (!m_fstart) chk("fstart_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        int k;
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        k = 0;
        do begin
            tick();
            k++;
        end while (!m_pushed && k < 600);
        if (!m_pushed) chk("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_left  = $urandom();
        in_right = $urandom();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_bck"}, 32'(bck), 32'd0);
        chk({tag, "_lrck"}, 32'(lrck), 32'd1);
        chk({tag, "_sdata"}, 32'(sdata), 32'd0);
        chk({tag, "_unr"}, 32'(underrun), 32'd0);
        chk({tag, "_level"}, 32'(fifo_level), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_left  = '0;
        in_right = '0;
        reset_model();
        #23;
        check_reset_vals("rst");
        @(posedge mck);
        #1;
        reset_n = 1'b1;

        // Single pair queued before the very first fall event.
        push_pair(24'h888888, 24'hF0F0F0);
        chk("level_one", 32'(fifo_level), 32'd1);
        wait_fstart();
        chk("level_popped", 32'(fifo_level), 32'd0);
        run(255);

        // Starvation: zero frames with an underrun pulse each.
        run(512);

        // Fill to full, then a fifth pair that must wait for the next pop.
        wait_fstart();
        push_pair(24'h1f3af0, 24'h000001);
        push_pair(24'h123456, 24'h000002);
        push_pair(24'h612345, 24'h000003);
        push_pair(24'h888888, 24'h000004);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        push_pair(24'hABCDEF, 24'h000005);
        run(256 * 6);

        // Last pair followed by starvation (hold-last or zeros).
        wait_fstart();
        push_pair(24'h123456, 24'h612345);
        wait_fstart();
        run(256 * 3);

        // Asynchronous reset in the middle of a frame with two pairs queued.
        wait_fstart();
        push_pair(24'h0A0A0A, 24'h505050);
        push_pair(24'h333333, 24'hCCCCCC);
        begin
            int k;
            k = 0;
            while (!(m_fall && m_cnt == 10) && k < 300) begin
                tick();
                k++;
            end
            if (!(m_fall && m_cnt == 10)) chk("cnt10_timeout", 32'd0, 32'd1);
        end
        chk("pre_rst_level", 32'(fifo_level), 32'd2);
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        @(posedge mck);
        @(posedge mck);
        #1;
        reset_model();
        reset_n = 1'b1;
        wait_fstart();
        chk("post_rst_unr", 32'(underrun), 32'd1);
        run(256 * 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2s_stream_tx.md
Name: i2s_stream_tx

Overview:
- I2S master transmitter running entirely on mck.
- Generates bck/lrck internally and accepts stereo sample pairs through a valid/ready handshake into a small FIFO.
- Serialises each pair MSB-first in standard I2S format: data is delayed one bck after each lrck edge, and the slot is zero-padded.
- Feeds the pedal's DAC path and any i2s_rx on the same bck/lrck/sdata lines.

Parameters:
- WIDTH, 24, sample width per channel.
- BITS_PER_SLOT, 32, bck periods per channel slot. Must satisfy BITS_PER_SLOT >= WIDTH+1.
- MCK_PER_BCK, 4, mck cycles per bck period. Must be even and >= 2.
- FIFO_DEPTH, 4, stereo pairs buffered. Must be a power of 2 and >= 2.

Ports:
- mck  input  1  system/master clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample pair offered.
- in_ready  output  1  FIFO can accept a pair.
- in_left  input  WIDTH  left sample.
- in_right  input  WIDTH  right sample.
- bck  output  1  bit clock, registered.
- lrck  output  1  word select, registered; 0 = left, 1 = right.
- sdata  output  1  serial data, registered.
- underrun  output  1  one-mck pulse when a frame starts with the FIFO empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  pairs currently stored.

Behaviour:
- Reset values (asynchronous):
  - bck=0, lrck=1, sdata=0, underrun=0, fifo_level=0, in_ready=1.
  - FIFO pointers cleared, shift registers 0.
  - bit_cnt=2*BITS_PER_SLOT-1, divider count=0.
- Divider:
  - Counts 0..MCK_PER_BCK-1, then wraps.
  - bck rises when the count reaches MCK_PER_BCK/2-1 and falls when it reaches MCK_PER_BCK-1.
  - First bck falling edge occurs MCK_PER_BCK cycles after reset release.
- "Fall event" is the mck edge on which bck goes 1->0. All of the following update only on fall events:
  - bit_cnt, modulo 2*BITS_PER_SLOT.
  - lrck, sdata.
  - FIFO pop.
- On a fall event, with p = new bit_cnt mod BITS_PER_SLOT:
  - lrck = (new bit_cnt >= BITS_PER_SLOT).
  - sdata = channel bit [WIDTH-p] when 1 <= p <= WIDTH; otherwise sdata = 0.
  - Since p=0 is always padding, the MSB appears one bck after the lrck edge.
- Frame start (fall event where bit_cnt wraps to 0):
  - FIFO non-empty: pop the head pair into the left/right shift registers in the same cycle.
  - FIFO empty: load zeros and pulse underrun for that one mck cycle.
- Handshake:
  - Push when in_valid && in_ready.
  - in_ready = (fifo_level != FIFO_DEPTH), computed from the registered level.
  - When full, in_ready stays 0 even on the cycle a pop occurs; it rises the following cycle.
- Simultaneous push and pop (not full): fifo_level unchanged and order preserved. A pair pushed into an empty FIFO on a frame-start cycle is not popped in that cycle; it is held for the next frame.
- fifo_level: +1 on push only, -1 on pop only; never exceeds FIFO_DEPTH or drops below 0.
- Reset mid-frame: asynchronous clear to reset values. Stored pairs are discarded, and the next frame restarts with left after MCK_PER_BCK cycles.
- in_left/in_right are sampled only on push; later changes do not affect queued data.

Optional Feature:
- Macro: I2S_TX_HOLD_LAST_EN.
- Defined: on an underrun frame, the shift registers reload the most recently transmitted pair instead of zeros (0 after reset). The underrun pulse is still generated.
- Undefined: an underrun frame transmits zeros; no hold register is synthesised.

Test Plan:
- Reset release with MCK_PER_BCK=4 -> bck=0, lrck=1, sdata=0, in_ready=1, fifo_level=0. First bck rise at mck cycle 2 and first fall at cycle 4 after release; lrck goes 0 on that fall.
- Push L=24'h888888, R=24'hF0F0F0 before the first fall -> fifo_level 1 then 0 at frame start. Left slot: sdata=0, then bits of 888888 MSB-first, then 7 zeros. Right slot: the same pattern for F0F0F0. Frame length 256 mck.
- No pushes -> underrun pulses once per 256 mck at each frame start; all 64 bits of the frame are 0.
- Push pairs 1f3af0/000001, 123456/000002, 612345/000003, 888888/000004 back to back -> fifo_level=4 and in_ready=0. A fifth pair is held by the bench. in_ready returns to 1 the cycle after the next frame-start pop, and the transmitted order matches push order.
- Drop reset_n at bit_cnt=10 with 2 pairs queued -> outputs return to reset values immediately and fifo_level=0. After release, the first frame underruns.
- With I2S_TX_HOLD_LAST_EN: send 123456/612345, then starve -> the next frame repeats 123456/612345 and underrun pulses. Without the macro, the same stimulus yields zeros.
